// File: rtl/t_trit_pkg.sv
// Shared ternary definitions: trit encodings, word sanitising and the neutral-word builder.
// Word helpers work on a MAX_W-trit container; callers slice out their own W trits.
package t_trit_pkg;

  localparam logic [1:0] TRIT_NEG  = 2'b01;
  localparam logic [1:0] TRIT_ZERO = 2'b11;
  localparam logic [1:0] TRIT_POS  = 2'b10;
  localparam logic [1:0] TRIT_INV  = 2'b00;

  localparam int MAX_W = 64;

  typedef logic [2*MAX_W-1:0] word_t;

  typedef struct packed {
    logic  any_inv;
    word_t word;
  } sanitised_t;

  typedef enum logic [1:0] {
    CH_EMPTY = 2'd0,
    CH_ONE   = 2'd1,
    CH_FULL  = 2'd2
  } ch_state_t;

  // Replace INVALID trits by ZERO in the low w trits and flag whether any were seen.
  function automatic sanitised_t sanitise_word(input word_t raw, input int w);
    sanitised_t r;
    r.any_inv = 1'b0;
    r.word    = raw;
    for (int i = 0; i < MAX_W; i++) begin
      if (i < w && raw[2*i +: 2] == TRIT_INV) begin
        r.word[2*i +: 2] = TRIT_ZERO;
        r.any_inv        = 1'b1;
      end
    end
    return r;
  endfunction

  function automatic word_t zero_word(input int w);
    word_t r;
    r = '0;
    for (int i = 0; i < MAX_W; i++) begin
      if (i < w) r[2*i +: 2] = TRIT_ZERO;
    end
    return r;
  endfunction

endpackage

// File: rtl/t_chan_buf.sv
// Two-entry trit-word FIFO for one output channel; the head is shown as an all-ZERO word
// whenever the buffer is empty so consumers never see stale data.
module t_chan_buf
  import t_trit_pkg::*;
#(
  parameter int W = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           push,
  input  logic [2*W-1:0] push_data,
  input  logic           ready,
  output logic           valid,
  output logic [2*W-1:0] data,
  output logic [1:0]     count
);

  localparam word_t          ZW_FULL   = zero_word(W);
  localparam logic [2*W-1:0] ZERO_WORD = ZW_FULL[2*W-1:0];

  ch_state_t      state_reg;
  logic [2*W-1:0] mem_reg [2];
  logic           rd_ptr_reg;
  logic           wr_ptr_reg;
  logic           pop;

  assign valid = (state_reg != CH_EMPTY);
  assign pop   = valid & ready;
  assign data  = valid ? mem_reg[rd_ptr_reg] : ZERO_WORD;
  assign count = (state_reg == CH_FULL) ? 2'd2 :
                 (state_reg == CH_ONE)  ? 2'd1 : 2'd0;

  // Storage is left unreset: the output mask hides it until a push makes it valid.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_reg[wr_ptr_reg] <= push_data;
    end
    if (!rst_n) begin
      state_reg  <= CH_EMPTY;
      rd_ptr_reg <= 1'b0;
      wr_ptr_reg <= 1'b0;
    end else begin
      if (push) wr_ptr_reg <= ~wr_ptr_reg;
      if (pop)  rd_ptr_reg <= ~rd_ptr_reg;
      case (state_reg)
        CH_EMPTY: if (push) state_reg <= CH_ONE;
        CH_ONE: begin
          if (push && !pop)      state_reg <= CH_FULL;
          else if (pop && !push) state_reg <= CH_EMPTY;
        end
        CH_FULL:  if (pop && !push) state_reg <= CH_ONE;
        default:  state_reg <= CH_EMPTY;
      endcase
    end
  end

endmodule

// File: rtl/t_deselect_router.sv
// Buffered ternary router: steers each accepted word to one channel or to all of them,
// sanitising invalid trits and counting words dropped for an out-of-range select.
module t_deselect_router
  import t_trit_pkg::*;
#(
  parameter int W    = 4,
  parameter int NCH  = 4,
  parameter int SELW = 2,
  parameter int DCW  = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [SELW-1:0]      in_sel,
  input  logic                 in_bcast,
  input  logic [2*W-1:0]       in_data,
  output logic [NCH-1:0]       out_valid,
  input  logic [NCH-1:0]       out_ready,
  output logic [NCH*2*W-1:0]   out_data,
  output logic                 err_invalid,
  output logic [DCW-1:0]       drop_cnt
);

  logic [1:0]     count   [NCH];
  logic [NCH-1:0] push;
  logic [SELW:0]  sel_ext;
  logic           sel_oor;
  logic           all_ready;
  logic           sel_ready;
  logic           accept;
  logic           drop;
  sanitised_t     clean;
  logic [2*W-1:0] clean_data;
  logic           unused_hi;
  logic           err_invalid_reg;
  logic [DCW-1:0] drop_cnt_reg;

  assign sel_ext = {1'b0, in_sel};
  assign sel_oor = (sel_ext >= (SELW+1)'(NCH));

  // Readiness looks only at registered occupancy, never at out_ready.
  always_comb begin
    all_ready = 1'b1;
    sel_ready = 1'b1;
    for (int c = 0; c < NCH; c++) begin
      if (count[c] == 2'd2) all_ready = 1'b0;
      if (sel_ext == (SELW+1)'(c)) sel_ready = (count[c] != 2'd2);
    end
  end

  assign in_ready = rst_n & (in_bcast ? all_ready : sel_ready);
  assign accept   = in_valid & in_ready;
  assign drop     = accept & ~in_bcast & sel_oor;

  assign clean      = sanitise_word({{(2*MAX_W-2*W){1'b0}}, in_data}, W);
  assign clean_data = clean.word[2*W-1:0];
  assign unused_hi  = ^clean.word[2*MAX_W-1:2*W];

  for (genvar gi = 0; gi < NCH; gi++) begin : g_chan
    assign push[gi] = accept & (in_bcast | (sel_ext == (SELW+1)'(gi)));

    t_chan_buf #(
      .W (W)
    ) u_buf (
      .clk       (clk),
      .rst_n     (rst_n),
      .push      (push[gi]),
      .push_data (clean_data),
      .ready     (out_ready[gi]),
      .valid     (out_valid[gi]),
      .data      (out_data[gi*2*W +: 2*W]),
      .count     (count[gi])
    );
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      err_invalid_reg <= 1'b0;
      drop_cnt_reg    <= '0;
    end else begin
      if (accept && clean.any_inv) err_invalid_reg <= 1'b1;
      if (drop && drop_cnt_reg != {DCW{1'b1}}) drop_cnt_reg <= drop_cnt_reg + 1'b1;
    end
  end

  assign err_invalid = err_invalid_reg;
  assign drop_cnt    = drop_cnt_reg;

endmodule

// File: doc/t_deselect_router.md
Name: t_deselect_router

Overview:
- Parametrised, buffered successor to the 4-trit ternary deselect.
- Routes one stream of binary-encoded ternary words to one of NCH output channels, or broadcasts to all. Each output channel has its own 2-entry buffer and valid/ready handshake.
- Non-selected or empty channels drive the neutral trit on every position.
- Sits between ternary datapath stages that need flow control, not a bare combinational steer.

Parameters:
- W, 4: trits per word; data buses are 2*W bits.
- NCH, 4: number of output channels, 2..16.
- SELW, 2: select width; must be at least ceil(log2(NCH)).
- DCW, 8: width of the drop counter.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  synchronous, active-low reset.
- in_valid  in  1  input word present.
- in_ready  out  1  router can accept the input word.
- in_sel  in  SELW  destination channel index.
- in_bcast  in  1  send the word to every channel; in_sel is ignored.
- in_data  in  2*W  trit word; trit i is at bits [2i+1:2i].
- out_valid  out  NCH  bit c: channel c buffer holds a word.
- out_ready  in  NCH  bit c: consumer of channel c accepts the head word.
- out_data  out  NCH*2*W  channel c word at bits [(c+1)*2W-1 : c*2W].
- err_invalid  out  1  sticky flag; an accepted word contained an invalid trit.
- drop_cnt  out  DCW  saturating count of words dropped because of an out-of-range select.

Behaviour:
- Trit encoding:
  - 2'b01 = NEG, 2'b11 = ZERO (neutral), 2'b10 = POS.
  - 2'b00 = INVALID.
- Accept condition: in_valid & in_ready, evaluated at the clock edge.
- in_ready is combinational from registered occupancy only. It never depends on out_ready in the same cycle, so there is no ready-to-ready combinational path.
  - in_bcast=1: in_ready = every channel count < 2.
  - in_bcast=0 and in_sel < NCH: in_ready = count[in_sel] < 2.
  - in_bcast=0 and in_sel >= NCH: in_ready = 1. The word is dropped and drop_cnt increments, saturating at 2^DCW-1.
- Sanitising on accept:
  - Every INVALID trit is stored as ZERO.
  - If any trit was INVALID, err_invalid is set on that edge. It stays set until reset.
  - A dropped word with invalid trits also sets err_invalid.
- Channel buffer: a 2-entry FIFO per channel.
  - Push on accept when the channel is targeted.
  - Pop when out_valid[c] & out_ready[c].
  - Push and pop in the same cycle: the count is unchanged and order is preserved.
  - Pop from empty and push to full cannot occur.
- Latency:
  - A word accepted on edge k appears on out_data of the target channel(s) after edge k, with out_valid high. This is 1 cycle.
  - Throughput is 1 word per cycle per channel when the consumer holds ready high.
- Output masking: when out_valid[c]=0, channel c's out_data is all ZERO (2'b11 per trit). It is never stale data.
- Reset (rst_n=0 at the edge):
  - All counts = 0; out_valid = 0; out_data = all ZERO.
  - err_invalid = 0; drop_cnt = 0.
  - in_ready while held in reset = 0.
  - Buffered words are discarded. Reset in the middle of a transfer needs no recovery.
- Broadcast waits for all channels to have space. Partial broadcasts never occur.
- State per channel: EMPTY (count 0), ONE (count 1), FULL (count 2).
  - EMPTY -> ONE on push.
  - ONE -> FULL on push without pop.
  - ONE -> EMPTY on pop without push.
  - FULL -> ONE on pop.
  - Push with pop keeps the current state.

Decomposition:
- Shared package t_trit_pkg contains:
  - Trit constants TRIT_NEG / TRIT_ZERO / TRIT_POS / TRIT_INV.
  - A word-sanitise function (INVALID -> ZERO, plus an any-invalid flag).
  - A ZERO-word constant builder for width W.
- One sub-module, t_chan_buf:
  - A 2-entry, 2*W-bit FIFO with count output and ZERO masking of its output.
  - Instantiated NCH times by a generate loop.

Test Plan:
- Reset then single write, with W=4, NCH=4: in_sel=2, in_data=8'b10_01_11_10, all out_ready=1 → out_valid=4'b0100 one cycle later and channel 2 = 8'b10_01_11_10. Other channels = 8'hFF; drop_cnt=0.
- Backpressure: out_ready[1]=0 and 3 consecutive words to channel 1 → first two accepted, in_ready=0 on the third. Raise out_ready[1] → words pop in order and the third is accepted one cycle after the first pop.
- Broadcast: in_bcast=1, data 8'b01_01_01_01, channel 3 FULL → in_ready=0 and no channel is written. Drain channel 3 → all four channels receive 8'h55 on the same edge.
- Out-of-range and invalid: NCH=3, in_sel=3, data 8'b00_10_11_01 → accepted with in_ready=1, drop_cnt=1, err_invalid=1, no out_valid change. Next a word 8'b00_00_10_10 to channel 0 → channel 0 = 8'b11_11_10_10.
- Simultaneous push/pop: channel 0 in ONE state, out_ready[0]=1 and a new word pushed in the same cycle → count stays 1 and out_data shows the new word next cycle.
- Mid-operation reset: two channels FULL, err_invalid=1, drop_cnt=5, then rst_n=0 for one edge → all out_valid=0, outputs 8'hFF, counters 0, in_ready=0 during reset and 1 afterwards.
